// File: rtl/dual_issue_pkg.sv
// Shared encodings for the dual-issue decode stage: opcodes, functs, ALUOp values,
// control-word bit offsets and the FSM state type.
package dual_issue_pkg;

    localparam int CTRL_W  = 15;
    localparam int ALUOP_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_SGT = 6'h2B;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SGT = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10
    } mem_to_reg_e;

    localparam int C_PCSRC    = 0;
    localparam int C_SIGNEXT  = 1;
    localparam int C_JUMP     = 2;
    localparam int C_ALUSRC   = 3;
    localparam int C_REGWRITE = 4;
    localparam int C_MEMWRITE = 5;
    localparam int C_ALUOP    = 6;
    localparam int C_MEMTOREG = 10;
    localparam int C_MEMREAD  = 12;
    localparam int C_BRANCH   = 13;
    localparam int C_REGDST   = 14;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_SPLIT  = 1'b1
    } state_e;

    typedef struct packed {
        logic    ok;
        alu_op_e op;
    } funct_dec_t;

    function automatic funct_dec_t decode_funct(input logic [5:0] funct);
        funct_dec_t res;
        res.ok = 1'b1;
        res.op = ALU_ADD;
        case (funct)
            F_ADD:   res.op = ALU_ADD;
            F_SUB:   res.op = ALU_SUB;
            F_AND:   res.op = ALU_AND;
            F_OR:    res.op = ALU_OR;
            F_XOR:   res.op = ALU_XOR;
            F_NOR:   res.op = ALU_NOR;
            F_SLT:   res.op = ALU_SLT;
            F_SLL:   res.op = ALU_SLL;
            F_SRL:   res.op = ALU_SRL;
            F_SGT:   res.op = ALU_SGT;
            default: res.ok = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dual_issue_decode_slot_decoder.sv
// Combinational decode of one instruction slot into control word, destination
// register and the classification flags used by the pairing check.
module slot_decoder
    import dual_issue_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic              slot_valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [4:0]        dest,
    output logic              illegal,
    output logic              is_mem,
    output logic              is_cti
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    funct_dec_t fdec;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign fdec          = decode_funct(funct);
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl    = '0;
        dest    = '0;
        illegal = 1'b0;
        is_mem  = 1'b0;
        is_cti  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == F_JR) begin
                    ctrl[C_REGDST] = 1'b1;
                    ctrl[C_PCSRC]  = 1'b1;
                    is_cti         = 1'b1;
                end else if (fdec.ok) begin
                    ctrl[C_REGDST]              = 1'b1;
                    ctrl[C_REGWRITE]            = 1'b1;
                    ctrl[C_ALUOP +: ALUOP_W]    = fdec.op;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LW: begin
                ctrl[C_MEMREAD]         = 1'b1;
                ctrl[C_MEMTOREG +: 2]   = MTR_MEM;
                ctrl[C_REGWRITE]        = 1'b1;
                ctrl[C_ALUSRC]          = 1'b1;
                is_mem                  = 1'b1;
            end
            OP_SW: begin
                ctrl[C_MEMWRITE] = 1'b1;
                ctrl[C_ALUSRC]   = 1'b1;
                is_mem           = 1'b1;
            end
            OP_ADDI, OP_ORI, OP_XORI, OP_ANDI, OP_SLTI: begin
                ctrl[C_REGWRITE] = 1'b1;
                ctrl[C_ALUSRC]   = 1'b1;
                case (opcode)
                    OP_ADDI: begin
                        ctrl[C_ALUOP +: ALUOP_W] = ALU_ADD;
                        ctrl[C_SIGNEXT]          = 1'b1;
                    end
                    OP_ORI:  ctrl[C_ALUOP +: ALUOP_W] = ALU_OR;
                    OP_XORI: ctrl[C_ALUOP +: ALUOP_W] = ALU_XOR;
                    OP_ANDI: ctrl[C_ALUOP +: ALUOP_W] = ALU_AND;
                    default: begin
                        ctrl[C_ALUOP +: ALUOP_W] = ALU_SLT;
                        ctrl[C_SIGNEXT]          = 1'b1;
                    end
                endcase
            end
            OP_BEQ, OP_BNE: begin
                ctrl[C_BRANCH] = 1'b1;
                is_cti         = 1'b1;
            end
            OP_J: begin
                ctrl[C_JUMP]  = 1'b1;
                ctrl[C_PCSRC] = 1'b1;
                is_cti        = 1'b1;
            end
            OP_JAL: begin
                ctrl[C_JUMP]          = 1'b1;
                ctrl[C_PCSRC]         = 1'b1;
                ctrl[C_REGWRITE]      = 1'b1;
                ctrl[C_REGDST]        = 1'b1;
                ctrl[C_MEMTOREG +: 2] = MTR_PC4;
                is_cti                = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (opcode == OP_JAL)     dest = 5'd31;
        else if (ctrl[C_REGDST])  dest = rd;
        else                      dest = rt;

        if (!slot_valid) begin
            ctrl    = '0;
            dest    = '0;
            illegal = 1'b0;
            is_mem  = 1'b0;
            is_cti  = 1'b0;
        end
    end

endmodule

// File: rtl/dual_issue_decode.sv
// Registered dual-issue decode stage: per-slot decode, pairing check and a
// NORMAL/SPLIT FSM that issues a conflicting bundle over two cycles.
// Optional macro ILLEGAL_TRAP_EN adds out_illegal and splits after an illegal slot0.
module dual_issue_decode
    import dual_issue_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int CTRL_W    = dual_issue_pkg::CTRL_W,
    parameter int ALUOP_W   = dual_issue_pkg::ALUOP_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [NUM_SLOTS-1:0]        in_slot_valid,
    input  logic [32*NUM_SLOTS-1:0]     in_instr,
    output logic                        in_ready,
    input  logic                        stall,
    input  logic                        flush,
    output logic [NUM_SLOTS-1:0]        out_valid,
    output logic [CTRL_W*NUM_SLOTS-1:0] out_ctrl,
    output logic [5*NUM_SLOTS-1:0]      out_dest,
    output logic [32*NUM_SLOTS-1:0]     out_instr
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic [NUM_SLOTS-1:0]        out_illegal
`endif
);

    localparam int HS = NUM_SLOTS - 1;

    if ((NUM_SLOTS != 1 && NUM_SLOTS != 2) || CTRL_W != dual_issue_pkg::CTRL_W ||
        ALUOP_W != dual_issue_pkg::ALUOP_W) begin : g_bad_cfg
        $error("dual_issue_decode: unsupported parameter combination");
    end

    logic [CTRL_W-1:0] slot_ctrl    [NUM_SLOTS];
    logic [4:0]        slot_dest    [NUM_SLOTS];
    logic              slot_illegal [NUM_SLOTS];
    logic              slot_is_mem  [NUM_SLOTS];
    logic              slot_is_cti  [NUM_SLOTS];
    logic              conflict;
    logic              accept;
    logic              unused_flags;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_decoder u_dec (
            .instr      (in_instr[32*i +: 32]),
            .slot_valid (in_slot_valid[i]),
            .ctrl       (slot_ctrl[i]),
            .dest       (slot_dest[i]),
            .illegal    (slot_illegal[i]),
            .is_mem     (slot_is_mem[i]),
            .is_cti     (slot_is_cti[i])
        );
    end

    if (NUM_SLOTS == 2) begin : g_pair
        logic [4:0] rs1;
        logic [4:0] rt1;
        logic       wr0;
        logic       wr1;
        logic       raw;
        logic       waw;
        logic       ill0;

        assign rs1 = in_instr[57:53];
        assign rt1 = in_instr[52:48];
        assign wr0 = slot_ctrl[0][C_REGWRITE];
        assign wr1 = slot_ctrl[1][C_REGWRITE];
        assign raw = wr0 && (slot_dest[0] != 5'd0) &&
                     (slot_dest[0] == rs1 || slot_dest[0] == rt1);
        assign waw = wr0 && wr1 && (slot_dest[0] != 5'd0) && (slot_dest[0] == slot_dest[1]);
`ifdef ILLEGAL_TRAP_EN
        assign ill0 = slot_illegal[0];
`else
        assign ill0 = 1'b0;
`endif
        assign conflict = in_slot_valid[0] && in_slot_valid[1] &&
                          ((slot_is_mem[0] && slot_is_mem[1]) || slot_is_cti[0] || raw || waw || ill0);
    end else begin : g_single
        assign conflict = 1'b0;
    end

    assign unused_flags = ^{slot_is_cti[HS], slot_is_mem[0], slot_illegal[0], slot_illegal[HS]};

    state_e                        state_q, state_d;
    logic [NUM_SLOTS-1:0]          out_valid_q, out_valid_d;
    logic [CTRL_W*NUM_SLOTS-1:0]   out_ctrl_q, out_ctrl_d;
    logic [5*NUM_SLOTS-1:0]        out_dest_q, out_dest_d;
    logic [32*NUM_SLOTS-1:0]       out_instr_q, out_instr_d;
    logic [CTRL_W-1:0]             hold_ctrl_q, hold_ctrl_d;
    logic [4:0]                    hold_dest_q, hold_dest_d;
    logic [31:0]                   hold_instr_q, hold_instr_d;
`ifdef ILLEGAL_TRAP_EN
    logic [NUM_SLOTS-1:0]          out_illegal_q, out_illegal_d;
    logic                          hold_illegal_q, hold_illegal_d;
`endif

    assign in_ready = !rst && !stall && !flush && (state_q == ST_NORMAL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_dest_d   = out_dest_q;
        out_instr_d  = out_instr_q;
        hold_ctrl_d  = hold_ctrl_q;
        hold_dest_d  = hold_dest_q;
        hold_instr_d = hold_instr_q;
`ifdef ILLEGAL_TRAP_EN
        out_illegal_d  = out_illegal_q;
        hold_illegal_d = hold_illegal_q;
`endif

        if (flush || (!stall && !accept)) begin
            // Bubble: nothing issues, and a flush also abandons any held slot1.
            out_valid_d = '0;
            out_ctrl_d  = '0;
            out_dest_d  = '0;
`ifdef ILLEGAL_TRAP_EN
            out_illegal_d = '0;
`endif
            if (flush || state_q == ST_SPLIT) begin
                if (state_q == ST_SPLIT && !flush) begin
                    out_valid_d[HS]             = 1'b1;
                    out_ctrl_d[CTRL_W*HS +: CTRL_W] = hold_ctrl_q;
                    out_dest_d[5*HS +: 5]       = hold_dest_q;
                    out_instr_d                 = '0;
                    out_instr_d[32*HS +: 32]    = hold_instr_q;
`ifdef ILLEGAL_TRAP_EN
                    out_illegal_d[HS]           = hold_illegal_q;
`endif
                end
                state_d = ST_NORMAL;
            end
        end else if (accept) begin
            out_valid_d = in_slot_valid;
            out_instr_d = in_instr;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                out_ctrl_d[CTRL_W*i +: CTRL_W] = slot_ctrl[i];
                out_dest_d[5*i +: 5]           = slot_dest[i];
`ifdef ILLEGAL_TRAP_EN
                out_illegal_d[i]               = slot_illegal[i];
`endif
            end
            if (conflict) begin
                hold_ctrl_d  = slot_ctrl[HS];
                hold_dest_d  = slot_dest[HS];
                hold_instr_d = in_instr[32*HS +: 32];
                out_valid_d[HS]                 = 1'b0;
                out_ctrl_d[CTRL_W*HS +: CTRL_W] = '0;
                out_dest_d[5*HS +: 5]           = '0;
                out_instr_d[32*HS +: 32]        = '0;
`ifdef ILLEGAL_TRAP_EN
                hold_illegal_d    = slot_illegal[HS];
                out_illegal_d[HS] = 1'b0;
`endif
                state_d = ST_SPLIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            out_valid_q  <= '0;
            out_ctrl_q   <= '0;
            out_dest_q   <= '0;
            out_instr_q  <= '0;
            // NOTE: the hold buffer is reset too, so a slot that was never captured can't leak X.
            hold_ctrl_q  <= '0;
            hold_dest_q  <= '0;
            hold_instr_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            out_illegal_q  <= '0;
            hold_illegal_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_dest_q   <= out_dest_d;
            out_instr_q  <= out_instr_d;
            hold_ctrl_q  <= hold_ctrl_d;
            hold_dest_q  <= hold_dest_d;
            hold_instr_q <= hold_instr_d;
`ifdef ILLEGAL_TRAP_EN
            out_illegal_q  <= out_illegal_d;
            hold_illegal_q <= hold_illegal_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_dest  = out_dest_q;
    assign out_instr = out_instr_q;
`ifdef ILLEGAL_TRAP_EN
    assign out_illegal = out_illegal_q;
`endif

endmodule

// File: tb/tb_dual_issue_decode.sv
// Directed self-checking bench for dual_issue_decode (NUM_SLOTS=2); optional
// ILLEGAL_TRAP_EN checks are compiled in when the macro is defined.
module tb_dual_issue_decode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_slot_valid;
    logic [63:0] in_instr;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [1:0]  out_valid;
    logic [29:0] out_ctrl;
    logic [9:0]  out_dest;
    logic [63:0] out_instr;
`ifdef ILLEGAL_TRAP_EN
    logic [1:0]  out_illegal;
`endif

    int checks   = 0;
    int failures = 0;

    dual_issue_decode #(.NUM_SLOTS(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_slot_valid (in_slot_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .stall         (stall),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ctrl      (out_ctrl),
        .out_dest      (out_dest),
        .out_instr     (out_instr)
`ifdef ILLEGAL_TRAP_EN
        ,
        .out_illegal   (out_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD   = 32'h00221820;
    localparam logic [31:0] I_ORI   = 32'h34A40010;
    localparam logic [31:0] I_LW    = 32'h8C220000;
    localparam logic [31:0] I_SW    = 32'hAC230004;
    localparam logic [31:0] I_ADDI8 = 32'h20080001;
    localparam logic [31:0] I_ADDI0 = 32'h20000001;
    localparam logic [31:0] I_ADD9  = 32'h01084820;
    localparam logic [31:0] I_JAL   = 32'h0C000010;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_BAD   = 32'hFC000000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sv, input logic [31:0] i0,
                         input logic [31:0] i1);
        in_valid      = v;
        in_slot_valid = sv;
        in_instr      = {i1, i0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        #2;
        check("reset_out_valid", {30'b0, out_valid}, 32'h0);
        check("reset_out_ctrl", {2'b0, out_ctrl}, 32'h0);
        check("reset_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", {31'b0, in_ready}, 32'h1);

        // add + ori pair
        drive(1'b1, 2'b11, I_ADD, I_ORI);
        check("pair_in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        check("pair_valid", {30'b0, out_valid}, 32'h3);
        check("pair_ctrl0", {17'b0, out_ctrl[14:0]}, 32'h4010);
        check("pair_dest0", {27'b0, out_dest[4:0]}, 32'd3);
        check("pair_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h00D8);
        check("pair_dest1", {27'b0, out_dest[9:5]}, 32'd4);
        check("pair_instr0", out_instr[31:0], I_ADD);
        check("pair_ready_after", {31'b0, in_ready}, 32'h1);

        // lw + sw: two memory ops split
        drive(1'b1, 2'b11, I_LW, I_SW);
        tick();
        check("mem_c1_valid", {30'b0, out_valid}, 32'h1);
        check("mem_c1_ctrl0", {17'b0, out_ctrl[14:0]}, 32'h1418);
        check("mem_c1_dest0", {27'b0, out_dest[4:0]}, 32'd2);
        check("mem_c1_ready", {31'b0, in_ready}, 32'h0);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        tick();
        check("mem_c2_valid", {30'b0, out_valid}, 32'h2);
        check("mem_c2_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h0028);
        check("mem_c2_dest1", {27'b0, out_dest[9:5]}, 32'd3);
        check("mem_c2_ready", {31'b0, in_ready}, 32'h1);

        // RAW on $8 splits; same bundle writing $0 pairs
        drive(1'b1, 2'b11, I_ADDI8, I_ADD9);
        tick();
        check("raw_c1_valid", {30'b0, out_valid}, 32'h1);
        check("raw_c1_ctrl0", {17'b0, out_ctrl[14:0]}, 32'h001A);
        check("raw_c1_dest0", {27'b0, out_dest[4:0]}, 32'd8);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        tick();
        check("raw_c2_valid", {30'b0, out_valid}, 32'h2);
        check("raw_c2_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h4010);
        check("raw_c2_dest1", {27'b0, out_dest[9:5]}, 32'd9);
        drive(1'b1, 2'b11, I_ADDI0, I_ADD9);
        tick();
        check("zero_dest_valid", {30'b0, out_valid}, 32'h3);
        check("zero_dest_ready", {31'b0, in_ready}, 32'h1);

        // JAL in slot0 splits
        drive(1'b1, 2'b11, I_JAL, I_NOP);
        tick();
        check("jal_c1_valid", {30'b0, out_valid}, 32'h1);
        check("jal_c1_ctrl0", {17'b0, out_ctrl[14:0]}, 32'h4815);
        check("jal_c1_dest0", {27'b0, out_dest[4:0]}, 32'd31);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        tick();
        check("jal_c2_valid", {30'b0, out_valid}, 32'h2);
        check("jal_c2_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h41D0);

        // JAL split then flush in the second cycle
        drive(1'b1, 2'b11, I_JAL, I_NOP);
        tick();
        check("flush_c1_valid", {30'b0, out_valid}, 32'h1);
        flush = 1'b1;
        drive(1'b1, 2'b11, I_ADD, I_ORI);
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        check("flush_c2_valid", {30'b0, out_valid}, 32'h0);
        flush = 1'b0;
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        #1;
        check("flush_back_normal", {31'b0, in_ready}, 32'h1);
        tick();
        check("flush_no_accept", {30'b0, out_valid}, 32'h0);

        // stall for three cycles mid-SPLIT
        drive(1'b1, 2'b11, I_LW, I_SW);
        tick();
        check("stall_c1_valid", {30'b0, out_valid}, 32'h1);
        stall = 1'b1;
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", {31'b0, in_ready}, 32'h0);
            tick();
            check("stall_valid", {30'b0, out_valid}, 32'h1);
            check("stall_ctrl0", {17'b0, out_ctrl[14:0]}, 32'h1418);
            check("stall_dest0", {27'b0, out_dest[4:0]}, 32'd2);
        end
        stall = 1'b0;
        #1;
        check("stall_release_ready", {31'b0, in_ready}, 32'h0);
        tick();
        check("stall_release_valid", {30'b0, out_valid}, 32'h2);
        check("stall_release_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h0028);
        check("stall_release_ready2", {31'b0, in_ready}, 32'h1);

        // asynchronous reset mid-SPLIT
        drive(1'b1, 2'b11, I_LW, I_SW);
        tick();
        check("arst_c1_valid", {30'b0, out_valid}, 32'h1);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {30'b0, out_valid}, 32'h0);
        check("arst_ctrl", {2'b0, out_ctrl}, 32'h0);
        check("arst_dest", {22'b0, out_dest}, 32'h0);
        check("arst_ready", {31'b0, in_ready}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_release_ready", {31'b0, in_ready}, 32'h1);
        tick();
        check("arst_no_held_issue", {30'b0, out_valid}, 32'h0);

        // partial bundle: slot1 absent
        drive(1'b1, 2'b01, I_ADD, I_ORI);
        tick();
        check("partial_valid", {30'b0, out_valid}, 32'h1);
        check("partial_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h0);
        check("partial_dest1", {27'b0, out_dest[9:5]}, 32'h0);
        check("partial_ready", {31'b0, in_ready}, 32'h1);

        // undefined opcode in slot1
        drive(1'b1, 2'b11, I_ADD, I_BAD);
        tick();
        check("illegal_valid", {30'b0, out_valid}, 32'h3);
        check("illegal_ctrl1", {17'b0, out_ctrl[29:15]}, 32'h0);
        check("illegal_ctrl0", {17'b0, out_ctrl[14:0]}, 32'h4010);
`ifdef ILLEGAL_TRAP_EN
        check("illegal_flag", {30'b0, out_illegal}, 32'h2);
`endif
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        tick();
        check("idle_valid", {30'b0, out_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
